// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the programmable synchronous FIFO.
// Read-mode selectors and pointer wrap helper.
package sync_fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Advance a pointer, wrapping to zero after depth-1 (any depth).
    function automatic logic [31:0] next_ptr(
        input logic [31:0] ptr,
        input logic [31:0] depth
    );
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/sync_fifo_prog_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// Storage is not reset; only the output register is.
module sync_sdp_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register loads only on a read enable.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    // Output register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with STD/FWFT read modes, programmable
// almost flags, occupancy count and sticky error flags.
module sync_fifo_prog
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int FWFT  = FIFO_STD,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    input  logic [CW-1:0]    af_thresh,
    input  logic [CW-1:0]    ae_thresh,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clr
);

    localparam int AW      = $clog2(DEPTH);
    localparam bit IS_FWFT = (FWFT == FIFO_FWFT);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] ram_cnt;
    logic          dv_q, dv_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          wr_acc;
    logic          rd_acc;
    logic          ram_re;

    // In FWFT the output register holds one of the counted words.
    assign ram_cnt = IS_FWFT ? count_q - CW'(dv_q) : count_q;

    assign full         = (count_q == CW'(DEPTH));
    assign empty        = IS_FWFT ? !dv_q : (count_q == '0);
    assign almost_full  = (count_q >= af_thresh);
    assign almost_empty = (count_q <= ae_thresh);
    assign count        = count_q;
    assign dout_valid   = dv_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // Acceptance, occupancy, pointer, prefetch and error-flag logic.
    always_comb begin
        wr_acc   = wr_en && !full;
        rd_acc   = rd_en && !empty;
        count_d  = count_q;
        ram_re   = 1'b0;
        dv_d     = dv_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CW'(1);
        end
        wr_ptr_d = wr_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = AW'(next_ptr(32'(wr_ptr_q), 32'(DEPTH)));
        end
        if (IS_FWFT) begin
            // Refill the output stage whenever it is free or being popped.
            ram_re = (ram_cnt != '0) && (!dv_q || rd_acc);
            dv_d   = ram_re || (dv_q && !rd_acc);
        end else begin
            ram_re = rd_acc;
            dv_d   = rd_acc;
        end
        rd_ptr_d = rd_ptr_q;
        if (ram_re) begin
            rd_ptr_d = AW'(next_ptr(32'(rd_ptr_q), 32'(DEPTH)));
        end
        // A new error event outranks a simultaneous clear.
        ovf_d = (wr_en && full) || (ovf_q && !err_clr);
        unf_d = (rd_en && empty) || (unf_q && !err_clr);
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dv_q     <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dv_q     <= dv_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    sync_sdp_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (din),
        .re    (ram_re),
        .raddr (rd_ptr_q),
        .rdata (dout)
    );

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Parametrised single-clock FIFO that succeeds the basic sync FIFO for datapath buffering between pipeline stages. It adds:
- selectable read mode: standard registered read, or first-word-fall-through (FWFT);
- runtime-programmable almost-full and almost-empty thresholds;
- an occupancy count output;
- separate sticky overflow and underflow flags with a clear input;
- support for non-power-of-two depth.

Storage is a synchronous-read simple-dual-port RAM, so it maps to block RAM.

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 32, total capacity in words (>=2, any integer)
FWFT, 0, read mode: 0 = standard (1-cycle read latency), 1 = first-word-fall-through
CW, $clog2(DEPTH+1), derived width of count and thresholds; not to be overridden

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous reset, active-low
wr_en  in  1  write request
din  in  WIDTH  write data
rd_en  in  1  read request (STD) / pop of presented word (FWFT)
dout  out  WIDTH  read data, registered
dout_valid  out  1  STD: one-cycle pulse when dout carries a popped word; FWFT: dout holds the head word
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= af_thresh
almost_empty  out  1  count <= ae_thresh
af_thresh  in  CW  almost-full threshold, sampled continuously
ae_thresh  in  CW  almost-empty threshold, sampled continuously
count  out  CW  words held, including the FWFT output-register word
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
err_clr  in  1  clears overflow/underflow

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low (rst_n).
- Reset (rst_n low at edge):
  - pointers, count, dout and dout_valid go to 0;
  - overflow and underflow go to 0;
  - RAM contents are not reset.
  - Reset mid-operation discards all data; the next cycle shows empty=1, full=0.
- Flags: full, empty, almost_* are combinational from count (and thresholds). After reset: almost_empty=1; almost_full=1 only if af_thresh==0.
- Write acceptance: wr_acc = wr_en && !full.
  - A write while full is dropped even if rd_en is high in the same cycle (no full bypass).
- Read acceptance: rd_acc = rd_en && !empty.
  - A read while empty is ignored, and dout is unchanged.
- Count: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
- Pointers: wr_ptr and rd_ptr range 0..DEPTH-1; each wraps to 0 after DEPTH-1.
- STD mode:
  - On rd_acc at edge k, RAM[rd_ptr] is loaded into dout at edge k. dout_valid is high for exactly the following cycle.
  - dout holds its value otherwise.
  - Write at edge k makes empty=0 after edge k.
- FWFT mode:
  - The RAM output register is dout; dout_valid = output stage occupied; empty = !dout_valid.
  - A prefetch read is issued when RAM is non-empty and (output stage empty or rd_acc).
  - A write into a totally empty FIFO at edge k gives dout_valid=1 after edge k+1.
  - Back-to-back pops sustain 1 word/cycle with no bubble.
  - full counts RAM words plus the output word; total capacity is DEPTH.
  - RAM never reads an address being written in the same cycle.
- Error flags:
  - overflow sets on wr_en && full; underflow sets on rd_en && empty.
  - err_clr clears both; a set event in the same cycle as err_clr wins.
- Thresholds may change at any time; the flags follow combinationally. Values above DEPTH are legal (almost_full then never asserts).

Decomposition:
- Package sync_fifo_pkg: mode constants FIFO_STD=0, FIFO_FWFT=1; function next_ptr(ptr, depth) implementing the wrap.
- Sub-module sync_sdp_ram: WIDTH x DEPTH, one write port, one synchronous read port with read-enable and registered output, no reset on storage.

Test Plan:
- STD, DEPTH=5: write 1..5 -> full=1 and count=5 after 5th edge. 6th write of 6 -> overflow=1, count stays 5. Read 5 -> dout 1..5, each valid the cycle after rd_en.
- FWFT, DEPTH=4: write 0xA at edge 0 -> dout=0xA and dout_valid=1 after edge 1. Write 0xB,0xC, then rd_en held 3 cycles -> dout 0xA,0xB,0xC consecutive, then empty=1.
- Wrap with DEPTH=5 (non-power-of-two): 12 writes interleaved with reads keeping count<=3 -> output order 0..11 exact, no loss.
- Simultaneous wr_en+rd_en at count=2 -> count stays 2, data order preserved. At count=0 (STD) -> write accepted, read rejected, underflow=1, count=1.
- Thresholds af=3, ae=1: count 0->1->2->3 -> almost_empty 1,1,0,0 and almost_full 0,0,0,1. Change af to 2 at count=2 -> almost_full=1 same cycle.
- err_clr with underflow set -> both flags 0 next cycle. err_clr coincident with read-while-empty -> underflow stays 1. rst_n low with count=3 -> count=0, empty=1, dout_valid=0 next cycle.
